// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with valid/ready handshake toward the MEM stage.
// Define EX_MEM_SKID_EN for a two-entry (main + skid) buffer with a registered ex_ready_o.
module ex_mem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [REG_AW-1:0] regdst_i,
    input  logic [DATA_W-1:0] branch_target_i,
    input  logic              d_regwrite_i,
    input  logic              d_memtoreg_i,
    input  logic              d_memread_i,
    input  logic              d_memwrite_i,
    input  logic              d_branch_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [DATA_W-1:0] branch_target_o,
    output logic [REG_AW-1:0] regdst_o,
    output logic              regwrite_o,
    output logic              memtoreg_o,
    output logic              memread_o,
    output logic              memwrite_o,
    output logic              pcsrc_o
);

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic              alu_zero;
        logic [DATA_W-1:0] store_data;
        logic [REG_AW-1:0] regdst;
        logic [DATA_W-1:0] branch_target;
        logic              regwrite;
        logic              memtoreg;
        logic              memread;
        logic              memwrite;
        logic              branch;
    } entry_t;

    entry_t in_entry;
    entry_t main_q;
    logic   main_valid;
    logic   accept;

    always_comb begin
        in_entry.alu_result    = alu_result_i;
        in_entry.alu_zero      = alu_zero_i;
        in_entry.store_data    = store_data_i;
        in_entry.regdst        = regdst_i;
        in_entry.branch_target = branch_target_i;
        in_entry.regwrite      = d_regwrite_i;
        in_entry.memtoreg      = d_memtoreg_i;
        in_entry.memread       = d_memread_i;
        in_entry.memwrite      = d_memwrite_i;
        in_entry.branch        = d_branch_i;
    end

`ifdef EX_MEM_SKID_EN
    entry_t skid_q;
    logic   skid_valid;
    logic   ready_q;
    entry_t main_d;
    entry_t skid_d;
    logic   main_valid_d;
    logic   skid_valid_d;

    // ex_ready_o comes straight from a flop, so mem_ready_i never reaches it combinationally.
    assign ex_ready_o = ready_q;
    assign accept     = ex_valid_i & ready_q;

    // NOTE: every next-state variable gets its hold value first so no path can infer a latch.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid;
        skid_d       = skid_q;
        skid_valid_d = skid_valid;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid || mem_ready_i) begin
            // Main slot frees up: the skid entry is older, so it moves in ahead of any new one.
            if (skid_valid) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    // NOTE: payload registers are reset too, because every output must read 0 during reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_q     <= '0;
            main_valid <= 1'b0;
            skid_q     <= '0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_valid <= main_valid_d;
            skid_q     <= skid_d;
            skid_valid <= skid_valid_d;
            ready_q    <= !skid_valid_d;
        end
    end
`else
    logic armed_q;

    // armed_q keeps ex_ready_o low during reset and releases it on the first clock afterward.
    assign ex_ready_o = armed_q & (!main_valid | mem_ready_i);
    assign accept     = ex_valid_i & ex_ready_o;

    // NOTE: payload registers are reset too, because every output must read 0 during reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_q     <= '0;
            main_valid <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            armed_q <= 1'b1;
            if (flush_i) begin
                main_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= in_entry;
                main_valid <= 1'b1;
            end else if (mem_ready_i) begin
                main_valid <= 1'b0;
            end
        end
    end
`endif

    // Data outputs keep the last captured value; control outputs are qualified by valid.
    assign mem_valid_o     = main_valid;
    assign alu_result_o    = main_q.alu_result;
    assign store_data_o    = main_q.store_data;
    assign branch_target_o = main_q.branch_target;
    assign regdst_o        = main_q.regdst;
    assign regwrite_o      = main_valid & main_q.regwrite;
    assign memtoreg_o      = main_valid & main_q.memtoreg;
    assign memread_o       = main_valid & main_q.memread;
    assign memwrite_o      = main_valid & main_q.memwrite;
    assign pcsrc_o         = main_valid & main_q.branch & main_q.alu_zero;

endmodule
